// File: rtl/if_stage_if.sv
// if_stage_if: fetch-stage bus (memory, hazard controls, IF/ID register); perf outputs exist only under IF_STAGE_PERF_EN
interface if_stage_if;
  logic        mem_conflict_i;
  logic        stall_i;
  logic        redirect_i;
  logic [15:0] redirect_pc_i;
  logic [15:0] imem_instr_i;
  logic [15:0] pc_o;
  logic [15:0] if_id_instr_o;
  logic [15:0] if_id_pc_o;
  logic        if_id_valid_o;
  logic [1:0]  fetch_state_o;
`ifdef IF_STAGE_PERF_EN
  logic [15:0] perf_fetch_o;
  logic [15:0] perf_bubble_o;
`endif
  modport master (
    input  mem_conflict_i, stall_i, redirect_i, redirect_pc_i, imem_instr_i,
    output pc_o, if_id_instr_o, if_id_pc_o, if_id_valid_o, fetch_state_o
`ifdef IF_STAGE_PERF_EN
    , output perf_fetch_o, perf_bubble_o
`endif
  );
  modport slave (
    output mem_conflict_i, stall_i, redirect_i, redirect_pc_i, imem_instr_i,
    input  pc_o, if_id_instr_o, if_id_pc_o, if_id_valid_o, fetch_state_o
`ifdef IF_STAGE_PERF_EN
    , input perf_fetch_o, perf_bubble_o
`endif
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction fetch with PC register, IF/ID register, redirect/stall/conflict handling; IF_STAGE_PERF_EN adds fetch/bubble counters
module if_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] PC_STEP   = 16'd4,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input logic clk,
  input logic rst,
  if_stage_if.master b
);
  typedef enum logic [1:0] {RESET_HOLD = 2'd0, RUN = 2'd1, CONFLICT = 2'd2} state_t;
  state_t      state;
  logic [15:0] pc, instr, ipc, pc_nxt;
  logic        valid, hold, fetch;
`ifdef IF_STAGE_PERF_EN
  logic [15:0] perf_fetch, perf_bubble;
  assign b.perf_fetch_o  = perf_fetch;
  assign b.perf_bubble_o = perf_bubble;
`endif
  assign b.pc_o          = pc;
  assign b.if_id_instr_o = instr;
  assign b.if_id_pc_o    = ipc;
  assign b.if_id_valid_o = valid;
  assign b.fetch_state_o = state;
  // Redirect beats stall; RESET_HOLD ignores every input and only loads a bubble.
  always_comb begin
    hold   = state != RESET_HOLD && !b.redirect_i && b.stall_i;
    fetch  = state != RESET_HOLD && !b.redirect_i && !b.stall_i && !b.mem_conflict_i;
    pc_nxt = state == RESET_HOLD ? pc : b.redirect_i ? b.redirect_pc_i : fetch ? pc + PC_STEP : pc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_HOLD;
      pc    <= RESET_PC;
      instr <= NOP_INSTR;
      ipc   <= 16'h0000;
      valid <= 1'b0;
`ifdef IF_STAGE_PERF_EN
      perf_fetch  <= 16'h0000;
      perf_bubble <= 16'h0000;
`endif
    end else begin
      state <= b.mem_conflict_i ? CONFLICT : RUN;
      pc    <= pc_nxt;
      if (!hold) begin
        instr <= fetch ? b.imem_instr_i : NOP_INSTR;
        ipc   <= fetch ? pc : 16'h0000;
        valid <= fetch;
      end
`ifdef IF_STAGE_PERF_EN
      if (fetch && perf_fetch != 16'hFFFF) perf_fetch <= perf_fetch + 16'd1;
      if (!hold && !fetch && perf_bubble != 16'hFFFF) perf_bubble <= perf_bubble + 16'd1;
`endif
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed stimulus pushes expected IF state into a queue; a monitor pops and compares after each edge
module tb_if_stage;
  logic clk = 0;
  logic rst = 1;
  if_stage_if bus();
  if_stage dut (.clk(clk), .rst(rst), .b(bus.master));
  always #5 clk = ~clk;

  logic [15:0] mem [0:16383];
  always_comb bus.imem_instr_i = mem[bus.pc_o[15:2]];

  typedef struct {
    string       nm;
    logic [15:0] pc, ins, ipc;
    logic        v;
    logic [1:0]  st;
    bit          perf;
    logic [15:0] pf, pb;
  } exp_t;
  exp_t q[$];
  int passed = 0, total = 0;

  task automatic chk(input string nm, input string f, input logic [15:0] a, input logic [15:0] e);
    total++;
    if (a !== e) $display("FAIL %s.%s got %h exp %h", nm, f, a, e);
    else passed++;
  endtask

  task automatic step(input string nm, input logic r, input logic mc, input logic st, input logic rd,
                      input logic [15:0] rpc, input logic [15:0] pc, input logic [15:0] ins,
                      input logic [15:0] ipc, input logic v, input logic [1:0] s,
                      input bit perf = 0, input logic [15:0] pf = 0, input logic [15:0] pb = 0);
    exp_t e;
    @(negedge clk);
    rst = r;
    bus.mem_conflict_i = mc;
    bus.stall_i = st;
    bus.redirect_i = rd;
    bus.redirect_pc_i = rpc;
    e.nm = nm; e.pc = pc; e.ins = ins; e.ipc = ipc; e.v = v; e.st = s;
    e.perf = perf; e.pf = pf; e.pb = pb;
    q.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, "pc", bus.pc_o, e.pc);
        chk(e.nm, "instr", bus.if_id_instr_o, e.ins);
        chk(e.nm, "ifpc", bus.if_id_pc_o, e.ipc);
        chk(e.nm, "valid", {15'd0, bus.if_id_valid_o}, {15'd0, e.v});
        chk(e.nm, "state", {14'd0, bus.fetch_state_o}, {14'd0, e.st});
`ifdef IF_STAGE_PERF_EN
        if (e.perf) begin
          chk(e.nm, "perf_fetch", bus.perf_fetch_o, e.pf);
          chk(e.nm, "perf_bubble", bus.perf_bubble_o, e.pb);
        end
`endif
      end
    end
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 16'(i * 3 + 16'h0100);
    mem[0] = 16'h4905; mem[1] = 16'hD824; mem[2] = 16'h2801; mem[3] = 16'h0800;
    mem[4] = 16'h1234; mem[10] = 16'h6A01; mem[12] = 16'h3C3C; mem[16383] = 16'hBEEF;
    bus.mem_conflict_i = 0; bus.stall_i = 0; bus.redirect_i = 0; bus.redirect_pc_i = 0;
    repeat (2) @(posedge clk);
    //   name      rst mc st rd rpc       pc        instr     ifpc      v  state
    step("reset",    1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 0, 0);
    step("hold",     0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 0, 1);
    step("run0",     0, 0, 0, 0, 16'h0000, 16'h0004, 16'h4905, 16'h0000, 1, 1);
    step("run1",     0, 0, 0, 0, 16'h0000, 16'h0008, 16'hD824, 16'h0004, 1, 1);
    step("run2",     0, 0, 0, 0, 16'h0000, 16'h000C, 16'h2801, 16'h0008, 1, 1, 1, 16'd3, 16'd1);
    step("stall0",   0, 0, 1, 0, 16'h0000, 16'h000C, 16'h2801, 16'h0008, 1, 1);
    step("stall1",   0, 0, 1, 0, 16'h0000, 16'h000C, 16'h2801, 16'h0008, 1, 1);
    step("stall2",   0, 0, 1, 0, 16'h0000, 16'h000C, 16'h2801, 16'h0008, 1, 1);
    step("unstall",  0, 0, 0, 0, 16'h0000, 16'h0010, 16'h0800, 16'h000C, 1, 1);
    step("conf0",    0, 1, 0, 0, 16'h0000, 16'h0010, 16'h0800, 16'h0000, 0, 2);
    step("conf1",    0, 1, 0, 0, 16'h0000, 16'h0010, 16'h0800, 16'h0000, 0, 2);
    step("confend",  0, 0, 0, 0, 16'h0000, 16'h0014, 16'h1234, 16'h0010, 1, 1);
    step("redir_st", 0, 0, 1, 1, 16'h0028, 16'h0028, 16'h0800, 16'h0000, 0, 1);
    step("target",   0, 0, 0, 0, 16'h0000, 16'h002C, 16'h6A01, 16'h0028, 1, 1);
    step("redir_mc", 0, 1, 0, 1, 16'hFFFC, 16'hFFFC, 16'h0800, 16'h0000, 0, 2);
    step("conf_tgt", 0, 1, 0, 0, 16'h0000, 16'hFFFC, 16'h0800, 16'h0000, 0, 2);
    step("wrap",     0, 0, 0, 0, 16'h0000, 16'h0000, 16'hBEEF, 16'hFFFC, 1, 1);
    step("postwrap", 0, 0, 0, 0, 16'h0000, 16'h0004, 16'h4905, 16'h0000, 1, 1);
    step("st_mc",    0, 1, 1, 0, 16'h0000, 16'h0004, 16'h4905, 16'h0000, 1, 2);
    step("st_mcend", 0, 0, 0, 0, 16'h0000, 16'h0008, 16'hD824, 16'h0004, 1, 1);
    step("redir_odd",0, 0, 0, 1, 16'h0031, 16'h0031, 16'h0800, 16'h0000, 0, 1);
    step("odd_fetch",0, 0, 0, 0, 16'h0000, 16'h0035, 16'h3C3C, 16'h0031, 1, 1);
    step("rst_redir",1, 0, 0, 1, 16'h0100, 16'h0000, 16'h0800, 16'h0000, 0, 0);
    step("hold_mc",  0, 1, 1, 0, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 0, 2);
    step("rerun",    0, 0, 0, 0, 16'h0000, 16'h0004, 16'h4905, 16'h0000, 1, 1, 1, 16'd1, 16'd1);
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) $display("FAIL drain got %0d pending exp 0", q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
